uart_imem_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 26 ++
 rtl/uart_rx.sv | 115 +++++++++++
 rtl/uart_imem_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART instruction-memory boot loader.
// Optional checksum support in the loader is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CHK,
        DONE
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Clocks per UART bit, truncated; callers must keep the result >= 4.
    function automatic int clks_per_bit(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, half-bit start confirmation, mid-bit sampling.
// Emits a one-cycle rx_valid with rx_byte, or a one-cycle rx_ferr when the stop bit is low.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic             rxMeta_q, rxSync_q, rxPrev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= RX_IDLE;
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rxMeta_q <= Rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rxPrev_q && !rxSync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at the half-bit point was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxSync_q, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rxSync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: header (N words, little-endian), then N big-endian words written to IMEM.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 115200,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Rx,
    input  logic              Load_req,
    output logic              ImemWrEn,
    output logic [ADDR_W-1:0] ImemWrAddr,
    output logic [31:0]       ImemWrData,
    output logic              CpuHold,
    output logic              Loading,
    output logic [ADDR_W:0]   WordCount,
    output logic              Err
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [16:0]      MAX_WORDS  = 17'(2 ** ADDR_W);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [7:0] rxByte;
    logic       rxValid;
    logic       rxFerr;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .Clk     (Clk),
        .Reset   (Reset),
        .Rx      (Rx),
        .rx_byte (rxByte),
        .rx_valid(rxValid),
        .rx_ferr (rxFerr)
    );

    loader_state_e     state_q, state_d;
    logic              loadReqPrev_q;
    logic [7:0]        hdrLo_q, hdrLo_d;
    logic [CNT_W-1:0]  nWords_q, nWords_d;
    logic [CNT_W-1:0]  wordCount_q, wordCount_d;
    logic [1:0]        byteIdx_q, byteIdx_d;
    logic [23:0]       asm_q, asm_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [31:0]       wrData_q, wrData_d;
    logic              cpuHold_q, cpuHold_d;
    logic              loading_q, loading_d;
    logic              err_q, err_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic              loadEdge;
    logic [15:0]       headerN;
    logic [CNT_W-1:0]  wordCountInc;
    logic              fail;

    assign loadEdge     = Load_req & ~loadReqPrev_q;
    assign headerN      = {rxByte, hdrLo_q};
    assign wordCountInc = wordCount_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= IDLE;
            loadReqPrev_q <= 1'b0;
            hdrLo_q       <= '0;
            nWords_q      <= '0;
            wordCount_q   <= '0;
            byteIdx_q     <= '0;
            asm_q         <= '0;
            wrEn_q        <= 1'b0;
            wrAddr_q      <= '0;
            wrData_q      <= '0;
            cpuHold_q     <= 1'b0;
            loading_q     <= 1'b0;
            err_q         <= 1'b0;
            timer_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            loadReqPrev_q <= Load_req;
            hdrLo_q       <= hdrLo_d;
            nWords_q      <= nWords_d;
            wordCount_q   <= wordCount_d;
            byteIdx_q     <= byteIdx_d;
            asm_q         <= asm_d;
            wrEn_q        <= wrEn_d;
            wrAddr_q      <= wrAddr_d;
            wrData_q      <= wrData_d;
            cpuHold_q     <= cpuHold_d;
            loading_q     <= loading_d;
            err_q         <= err_d;
            timer_q       <= timer_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        hdrLo_d     = hdrLo_q;
        nWords_d    = nWords_q;
        wordCount_d = wordCount_q;
        byteIdx_d   = byteIdx_q;
        asm_d       = asm_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        cpuHold_d   = cpuHold_q;
        loading_d   = loading_q;
        err_d       = err_q;
        fail        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        // A received byte always reloads the idle timer, even on the expiry cycle.
        if (rxValid) begin
            timer_d = TMR_RELOAD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            IDLE: begin
                if (loadEdge) begin
                    state_d     = HDR0;
                    err_d       = 1'b0;
                    wordCount_d = '0;
                    byteIdx_d   = '0;
                    cpuHold_d   = 1'b1;
                    loading_d   = 1'b1;
                    timer_d     = TMR_RELOAD;
`ifdef LOADER_CHECKSUM_EN
                    chk_d       = '0;
`endif
                end
            end
            HDR0: begin
                if (rxValid) begin
                    hdrLo_d = rxByte;
                    state_d = HDR1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rxByte;
`endif
                end
            end
            HDR1: begin
                if (rxValid) begin
                    if (headerN == 16'd0 || {1'b0, headerN} > MAX_WORDS) begin
                        fail = 1'b1;
                    end else begin
                        nWords_d = CNT_W'(headerN);
                        state_d  = DATA;
                    end
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ rxByte;
`endif
                end
            end
            DATA: begin
                if (rxValid) begin
                    asm_d     = {asm_q[15:0], rxByte};
                    byteIdx_d = byteIdx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = chk_q ^ rxByte;
`endif
                    if (byteIdx_q == 2'd3) begin
                        byteIdx_d   = '0;
                        wrEn_d      = 1'b1;
                        wrAddr_d    = wordCount_q[ADDR_W-1:0];
                        wrData_d    = {asm_q, rxByte};
                        wordCount_d = wordCountInc;
                        if (wordCountInc == nWords_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (rxValid) begin
                    if (rxByte == chk_q) begin
                        state_d = DONE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                cpuHold_d = 1'b0;
                loading_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && state_q != DONE) begin
            if (rxFerr || (!rxValid && timer_q == '0)) begin
                fail = 1'b1;
            end
        end

        // CpuHold is deliberately left set so a partial image never runs.
        if (fail) begin
            state_d   = IDLE;
            err_d     = 1'b1;
            loading_d = 1'b0;
        end
    end

    assign ImemWrEn   = wrEn_q;
    assign ImemWrAddr = wrAddr_q;
    assign ImemWrData = wrData_q;
    assign CpuHold    = cpuHold_q;
    assign Loading    = loading_q;
    assign WordCount  = wordCount_q;
    assign Err        = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader (10 clocks per bit, 16-word IMEM, 500-cycle timeout).
// Checksum scenarios are exercised when LOADER_CHECKSUM_EN is defined.
module tb_uart_imem_loader;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int ADDR_W   = 4;
    localparam int TO       = 500;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int CAP      = 2 ** ADDR_W;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Rx = 1'b1;
    logic              Load_req = 1'b0;
    logic              ImemWrEn;
    logic [ADDR_W-1:0] ImemWrAddr;
    logic [31:0]       ImemWrData;
    logic              CpuHold;
    logic              Loading;
    logic [ADDR_W:0]   WordCount;
    logic              Err;

    uart_imem_loader #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Rx        (Rx),
        .Load_req  (Load_req),
        .ImemWrEn  (ImemWrEn),
        .ImemWrAddr(ImemWrAddr),
        .ImemWrData(ImemWrData),
        .CpuHold   (CpuHold),
        .Loading   (Loading),
        .WordCount (WordCount),
        .Err       (Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        longint            cyc;
    } wr_t;

    typedef struct {
        logic [7:0] hdrLo;
        logic [7:0] hdrHi;
        logic       expErr;
        int         expCount;
    } vec_t;

    int     checks = 0;
    int     fails = 0;
    longint cycle = 0;
    longint holdFallCyc = -1;
    logic   holdPrev = 1'b0;
    wr_t    wrLog[$];

    always @(posedge Clk) cycle++;

    // Observe writes and the CpuHold release away from the active edge.
    always @(negedge Clk) begin
        if (ImemWrEn === 1'b1) wrLog.push_back('{ImemWrAddr, ImemWrData, cycle});
        if (holdPrev && CpuHold === 1'b0) holdFallCyc = cycle;
        holdPrev = (CpuHold === 1'b1);
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        Rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            tick(CPB);
        end
        Rx = stopBit;
        tick(CPB);
        Rx = 1'b1;
        tick(CPB);
    endtask

    task automatic pulseLoad();
        Load_req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("start_hold", CpuHold, 1);
        checkOutput("start_loading", Loading, 1);
        checkOutput("start_err_clear", Err, 0);
        checkOutput("start_wc_clear", WordCount, 0);
        tick(1);
        Load_req = 1'b0;
    endtask

    // Reference: N from the little-endian header, words big-endian from the payload.
    task automatic applyStimulus(input logic [7:0] stream[$], input string tag);
        int         n;
        logic       expErr;
        logic [7:0] cs;
        logic [31:0] expWords[$];
        n = int'(stream[0]) + 256 * int'(stream[1]);
        expErr = (n == 0) || (n > CAP);
        cs = 8'h00;
        foreach (stream[i]) cs ^= stream[i];
        if (!expErr)
            for (int w = 0; w < n; w++)
                expWords.push_back({stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]});
        pulseLoad();
        wrLog.delete();
        holdFallCyc = -1;
        if (expErr) begin
            sendByte(stream[0], 1'b1);
            sendByte(stream[1], 1'b1);
        end else begin
            foreach (stream[i]) sendByte(stream[i], 1'b1);
`ifdef LOADER_CHECKSUM_EN
            sendByte(cs, 1'b1);
`endif
        end
        tick(20);
        checkOutput({tag, "_err"}, Err, expErr);
        checkOutput({tag, "_loading"}, Loading, 0);
        checkOutput({tag, "_hold"}, CpuHold, expErr);
        checkOutput({tag, "_wordcount"}, WordCount, expWords.size());
        checkOutput({tag, "_nwrites"}, wrLog.size(), expWords.size());
        for (int i = 0; i < expWords.size() && i < wrLog.size(); i++) begin
            checkOutput({tag, "_addr"}, wrLog[i].addr, i);
            checkOutput({tag, "_data"}, wrLog[i].data, expWords[i]);
        end
`ifndef LOADER_CHECKSUM_EN
        if (!expErr && wrLog.size() > 0)
            checkOutput({tag, "_holdfall"}, holdFallCyc, wrLog[wrLog.size()-1].cyc + 1);
`endif
    endtask

    function automatic void buildStream(input int n, output logic [7:0] s[$]);
        s.delete();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n >= 1 && n <= CAP)
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(0, 255)));
    endfunction

    vec_t       vecs[6];
    logic [7:0] s[$];

    initial begin
        vecs[0] = '{8'h02, 8'h00, 1'b0, 2};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 0};
        vecs[2] = '{8'h11, 8'h00, 1'b1, 0};
        vecs[3] = '{8'h10, 8'h00, 1'b0, 16};
        vecs[4] = '{8'h01, 8'h01, 1'b1, 0};
        vecs[5] = '{8'h01, 8'h00, 1'b0, 1};

        tick(5);
        checkOutput("rst_wren", ImemWrEn, 0);
        checkOutput("rst_addr", ImemWrAddr, 0);
        checkOutput("rst_data", ImemWrData, 0);
        checkOutput("rst_hold", CpuHold, 0);
        checkOutput("rst_loading", Loading, 0);
        checkOutput("rst_wc", WordCount, 0);
        checkOutput("rst_err", Err, 0);
        Reset = 1'b1;
        tick(3);

        // Bytes arriving while idle must not write anything.
        sendByte(8'h55, 1'b1);
        sendByte(8'h01, 1'b1);
        tick(5);
        checkOutput("idle_nwrites", wrLog.size(), 0);
        checkOutput("idle_loading", Loading, 0);
        checkOutput("idle_hold", CpuHold, 0);

        s = '{8'h02, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        applyStimulus(s, "basic");
        if (wrLog.size() == 2) begin
            checkOutput("basic_w0", {wrLog[0].addr, wrLog[0].data}, {4'd0, 32'h12345678});
            checkOutput("basic_w1", {wrLog[1].addr, wrLog[1].data}, {4'd1, 32'h9ABCDEF0});
        end

        for (int v = 0; v < 6; v++) begin
            buildStream(int'(vecs[v].hdrLo) + 256 * int'(vecs[v].hdrHi), s);
            applyStimulus(s, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_tbl_err", v), Err, vecs[v].expErr);
            checkOutput($sformatf("vec%0d_tbl_wc", v), WordCount, vecs[v].expCount);
        end

        // Framing error on the third data byte.
        pulseLoad();
        wrLog.delete();
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'hAA, 1'b1);
        sendByte(8'hBB, 1'b1);
        sendByte(8'hCC, 1'b0);
        tick(5);
        checkOutput("ferr_err", Err, 1);
        checkOutput("ferr_loading", Loading, 0);
        checkOutput("ferr_hold", CpuHold, 1);
        sendByte(8'hDD, 1'b1);
        tick(5);
        checkOutput("ferr_nwrites", wrLog.size(), 0);
        buildStream(1, s);
        applyStimulus(s, "after_ferr");

        // Silence after the header must time out about TO cycles after the last byte.
        pulseLoad();
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        tick(470);
        checkOutput("tmo_early_err", Err, 0);
        checkOutput("tmo_early_loading", Loading, 1);
        tick(30);
        checkOutput("tmo_err", Err, 1);
        checkOutput("tmo_loading", Loading, 0);
        checkOutput("tmo_hold", CpuHold, 1);
        tick(100);

        // Reset mid-load clears everything without flagging an error.
        pulseLoad();
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h11, 1'b1);
        sendByte(8'h22, 1'b1);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("mid_rst_hold", CpuHold, 0);
        checkOutput("mid_rst_loading", Loading, 0);
        checkOutput("mid_rst_wc", WordCount, 0);
        checkOutput("mid_rst_err", Err, 0);
        checkOutput("mid_rst_wren", ImemWrEn, 0);
        tick(3);
        buildStream(1, s);
        applyStimulus(s, "after_rst");

`ifdef LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(s, "chk_ok");
        pulseLoad();
        wrLog.delete();
        foreach (s[i]) sendByte(s[i], 1'b1);
        sendByte(8'h00, 1'b1);
        tick(10);
        checkOutput("chk_bad_err", Err, 1);
        checkOutput("chk_bad_hold", CpuHold, 1);
        checkOutput("chk_bad_nwrites", wrLog.size(), 1);
`endif

        // Random loads, occasionally with an out-of-range header.
        for (int r = 0; r < 5; r++) begin
            int n;
            if ($urandom_range(0, 3) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(CAP + 1, 300);
            else n = $urandom_range(1, CAP);
            buildStream(n, s);
            applyStimulus(s, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
